// File: rtl/stack_pkg.sv
// Shared constants, types and decode helpers for the LIFO stack block.
// Optional feature: STACK_ERR_EN adds the sticky overflow/underflow err port.
package stack_pkg;

  localparam int STACK_WIDTH_DEF = 8;
  localparam int STACK_DEPTH_DEF = 16;

  localparam int ERR_OVF = 1;
  localparam int ERR_UDF = 0;

  typedef struct packed {
    logic do_push;
    logic do_pop;
    logic do_tos;
  } op_dec_t;

  // push+pop is a conflict and cancels both; tos only acts when neither is requested.
  function automatic op_dec_t decode_op(input logic push, input logic pop,
                                        input logic tos, input logic is_empty,
                                        input logic is_full);
    op_dec_t dec;
    dec.do_push = push & ~pop & ~is_full;
    dec.do_pop  = pop & ~push & ~is_empty;
    dec.do_tos  = tos & ~push & ~pop & ~is_empty;
    return dec;
  endfunction

  // Returns error events indexed by ERR_OVF / ERR_UDF for this cycle's request.
  function automatic logic [1:0] err_events(input logic push, input logic pop,
                                            input logic tos, input logic is_empty,
                                            input logic is_full);
    logic [1:0] ev;
    logic       conflict;
    conflict     = push & pop;
    ev           = 2'b00;
    ev[ERR_OVF]  = (push & ~pop & is_full) | conflict;
    ev[ERR_UDF]  = (pop & ~push & is_empty) | (tos & ~push & ~pop & is_empty) | conflict;
    return ev;
  endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module stack_ram
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH_DEF,
  parameter int DEPTH = STACK_DEPTH_DEF,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stack_unit.sv
// LIFO stack with registered read data and combinational occupancy flags.
// Define STACK_ERR_EN to add the sticky {overflow, underflow} err output.
module stack_unit
  import stack_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH_DEF,
  parameter int DEPTH = STACK_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     tos,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
`ifdef STACK_ERR_EN
  ,output logic [1:0]              err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0]    sp_q, sp_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             ram_we;
  op_dec_t          dec;

  assign empty = (sp_q == '0);
  assign full  = (sp_q == DEPTH_C);
  assign count = sp_q;
  assign dout  = dout_q;

  assign dec = decode_op(push, pop, tos, empty, full);

  // sp points at the next free slot, so the top entry lives at sp-1.
  assign rd_addr = sp_q[AW-1:0] - ONE_A;
  // Gating with rst keeps a push coinciding with reset from landing in memory.
  assign ram_we  = dec.do_push & ~rst;

  stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (sp_q[AW-1:0]),
    .wdata_i (din),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_comb begin
    sp_d   = sp_q;
    dout_d = dout_q;
    if (dec.do_push) begin
      sp_d = sp_q + ONE_C;
    end else if (dec.do_pop) begin
      sp_d   = sp_q - ONE_C;
      dout_d = rd_data;
    end else if (dec.do_tos) begin
      dout_d = rd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q   <= '0;
      dout_q <= '0;
    end else begin
      sp_q   <= sp_d;
      dout_q <= dout_d;
    end
  end

`ifdef STACK_ERR_EN
  logic [1:0] err_q, err_d;

  always_comb begin
    err_d = err_q | err_events(push, pop, tos, empty, full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 2'b00;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_stack_unit.sv
// Self-checking bench for stack_unit: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_stack_unit;

  localparam int W = 8;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         push, pop, tos;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic         empty, full;
  logic [4:0]   count;
`ifdef STACK_ERR_EN
  logic [1:0]   err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .tos   (tos),
    .din   (din),
    .dout  (dout),
    .empty (empty),
    .full  (full),
    .count (count)
`ifdef STACK_ERR_EN
    ,.err  (err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         p;
    logic         o;
    logic         t;
    logic [W-1:0] d;
    logic [W-1:0] ed;
    logic [4:0]   ec;
  } vec_t;

  vec_t vecs [16];

  // reference model state
  logic [W-1:0] model_q [$];
  logic [W-1:0] exp_dout;
  logic [1:0]   exp_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic p, input logic o, input logic t, input logic [W-1:0] d);
    push = p;
    pop  = o;
    tos  = t;
    din  = d;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    tos  = 1'b0;
  endtask

  task automatic check_state(input string name, input logic [W-1:0] ed, input logic [4:0] ec);
    chk({name, ".dout"},  32'(dout),  32'(ed));
    chk({name, ".count"}, 32'(count), 32'(ec));
    chk({name, ".empty"}, 32'(empty), 32'(ec == 5'd0));
    chk({name, ".full"},  32'(full),  32'(ec == 5'(D)));
  endtask

  task automatic do_reset();
    push = 1'b0;
    pop  = 1'b0;
    tos  = 1'b0;
    din  = '0;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
  endtask

  // Applies one operation to the queue model using the stack's rules.
  task automatic model_op(input logic p, input logic o, input logic t, input logic [W-1:0] d);
    if (p && o) begin
      exp_err = 2'b11;
    end else if (p) begin
      if (model_q.size() < D) model_q.push_back(d);
      else exp_err[1] = 1'b1;
    end else if (o) begin
      if (model_q.size() > 0) exp_dout = model_q.pop_back();
      else exp_err[0] = 1'b1;
    end else if (t) begin
      if (model_q.size() > 0) exp_dout = model_q[$];
      else exp_err[0] = 1'b1;
    end
  endtask

  initial begin
    rst  = 1'b1;
    push = 1'b0;
    pop  = 1'b0;
    tos  = 1'b0;
    din  = '0;

    // push, pop, tos, din, expected dout, expected count
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h11, 8'h00, 5'd1};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h22, 8'h00, 5'd2};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h33, 8'h00, 5'd3};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h33, 5'd2};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h22, 5'd1};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h11, 5'd0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h5A, 8'h11, 5'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h5A, 5'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h5A, 5'd1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h5A, 5'd0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h5A, 5'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h5A, 5'd0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 8'h01, 8'h5A, 5'd1};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h77, 8'h5A, 5'd1};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h5A, 5'd1};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h01, 5'd0};

    // reset state
    do_reset();
    check_state("reset", 8'h00, 5'd0);
`ifdef STACK_ERR_EN
    chk("reset.err", 32'(err), 32'd0);
`endif

    // vector table
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].p, vecs[i].o, vecs[i].t, vecs[i].d);
      check_state($sformatf("vec%0d", i), vecs[i].ed, vecs[i].ec);
    end

    // fill to full, then overflow push
    do_reset();
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, 1'b0, 8'(8'hA0 + i));
    check_state("fill", 8'h00, 5'd16);
    step(1'b1, 1'b0, 1'b0, 8'hFF);
    check_state("ovf_push", 8'h00, 5'd16);
`ifdef STACK_ERR_EN
    chk("ovf_push.err", 32'(err), 32'b10);
`endif
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check_state("ovf_tos", 8'hAF, 5'd16);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check_state("ovf_pop", 8'hAF, 5'd15);

    // underflow from reset
    do_reset();
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check_state("udf_pop", 8'h00, 5'd0);
`ifdef STACK_ERR_EN
    chk("udf_pop.err", 32'(err), 32'b01);
`endif
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check_state("udf_tos", 8'h00, 5'd0);
    step(1'b1, 1'b0, 1'b0, 8'h3C);
    check_state("udf_recover", 8'h00, 5'd1);
`ifdef STACK_ERR_EN
    chk("udf_sticky.err", 32'(err), 32'b01);
`endif

    // push+pop conflict
    do_reset();
    step(1'b1, 1'b0, 1'b0, 8'h01);
    step(1'b1, 1'b1, 1'b0, 8'h77);
    check_state("conflict", 8'h00, 5'd1);
`ifdef STACK_ERR_EN
    chk("conflict.err", 32'(err), 32'b11);
`endif
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check_state("conflict_pop", 8'h01, 5'd0);

    // asynchronous reset mid-sequence
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    step(1'b0, 1'b0, 1'b1, 8'h00);
    check_state("pre_async", 8'h44, 5'd5);
    #2;
    rst = 1'b1;
    #1;
    check_state("async_rst", 8'h00, 5'd0);
    push = 1'b1;
    din  = 8'hEE;
    @(posedge clk);
    #1;
    push = 1'b0;
    rst  = 1'b0;
    check_state("rst_beats_push", 8'h00, 5'd0);
    step(1'b1, 1'b0, 1'b0, 8'h9C);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check_state("post_rst_pop", 8'h9C, 5'd0);

    // randomized traffic against the queue model
    do_reset();
    model_q.delete();
    exp_dout = '0;
    exp_err  = 2'b00;
    for (int i = 0; i < 600; i++) begin
      logic p, o, t;
      logic [W-1:0] d;
      if (i < 300) begin
        p = ($urandom_range(0, 99) < 60);
        o = ($urandom_range(0, 99) < 30);
      end else begin
        p = ($urandom_range(0, 99) < 30);
        o = ($urandom_range(0, 99) < 60);
      end
      t = ($urandom_range(0, 3) == 0);
      d = W'($urandom);
      model_op(p, o, t, d);
      step(p, o, t, d);
      check_state($sformatf("rnd%0d", i), exp_dout, 5'(model_q.size()));
`ifdef STACK_ERR_EN
      chk($sformatf("rnd%0d.err", i), 32'(err), 32'(exp_err));
`endif
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
